load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_align.sv | 43 ++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: access modes, FSM states, access size.
// Latency: none, this package holds only types, constants and a pure function.
// Backpressure: not applicable.
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_D  = 3'b011,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101,
        MODE_WU = 3'b110
    } mode_e;

    // Encoding 111 is reserved and always rejected.
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Number of byte lanes touched by an access of the given mode.
    // The reserved encoding reports one lane; it never reaches the bus.
    function automatic logic [3:0] mode_bytes(input logic [2:0] mode);
        case (mode)
            MODE_B, MODE_BU: return 4'd1;
            MODE_H, MODE_HU: return 4'd2;
            MODE_W, MODE_WU: return 4'd4;
            MODE_D:          return 4'd8;
            default:         return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering: byte enables and store shift toward the bus, right-align and extend for loads.
// Latency: purely combinational.
// Backpressure: none, follows its inputs.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       i_mode,
    input  logic [OFF_W-1:0] i_off,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [XLEN-1:0]  i_rdata,
    output logic [NB-1:0]    o_be,
    output logic [XLEN-1:0]  o_wdata,
    output logic [XLEN-1:0]  o_rdata
);

    logic [OFF_W+2:0] w_bitoff;
    logic [NB-1:0]    w_mask;
    logic [XLEN-1:0]  w_shr;

    // Build the lane mask, move store data up to its lanes and bring load data down to bit 0
    always_comb begin
        w_bitoff = {i_off, 3'b000};
        w_mask   = NB'((9'd1 << mode_bytes(i_mode)) - 9'd1);
        o_be     = w_mask << i_off;
        o_wdata  = i_wdata << w_bitoff;
        w_shr    = i_rdata >> w_bitoff;
        case (i_mode)
            MODE_B:  o_rdata = XLEN'($signed(w_shr[7:0]));
            MODE_BU: o_rdata = XLEN'(w_shr[7:0]);
            MODE_H:  o_rdata = XLEN'($signed(w_shr[15:0]));
            MODE_HU: o_rdata = XLEN'(w_shr[15:0]);
            MODE_W:  o_rdata = XLEN'($signed(w_shr[31:0]));
            MODE_WU: o_rdata = XLEN'(w_shr[31:0]);
            MODE_D:  o_rdata = w_shr;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging a core request port to a simple ack-based bus.
// Latency: accept at N, bus_req from N+1, response one cycle after ack or timeout; illegal accesses answer at N+1.
// Backpressure: req_ready only while idle; responses and bus requests cannot be stalled.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [XLEN/8-1:0] bus_be,
    output logic [XLEN-1:0]   bus_wdata,
    input  logic              bus_ack,
    input  logic [XLEN-1:0]   bus_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_we;
    logic [2:0]        r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;
    logic              r_err;
    logic [7:0]        r_cnt;

    logic              w_accept;
    logic              w_illegal;
    logic              w_timeout;
    logic [3:0]        w_bytes;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_bus_wdata;
    logic [XLEN-1:0]   w_ldata;

    // Reject reserved modes, sizes wider than the bus and accesses not aligned to their size
    always_comb begin
        w_bytes   = mode_bytes(req_mode);
        w_illegal = 1'b0;
        if (req_mode == MODE_RSVD) begin
            w_illegal = 1'b1;
        end
        if ((XLEN == 32) && ((req_mode == MODE_D) || (req_mode == MODE_WU))) begin
            w_illegal = 1'b1;
        end
        if ((req_addr[OFF_W-1:0] & OFF_W'(w_bytes - 4'd1)) != '0) begin
            w_illegal = 1'b1;
        end
    end

    assign w_accept  = req_valid && req_ready;
    // The wait that would bring the counter to TIMEOUT is the last one allowed.
    assign w_timeout = (r_cnt + 8'd1) == 8'(TIMEOUT);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-state handshake outputs; ack wins over a simultaneous timeout
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        bus_req     = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_illegal ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                bus_req = 1'b1;
                if (bus_ack || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the access, count bus waits and capture the extended load result
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_mode  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_we    <= req_we;
                        r_mode  <= req_mode;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rdata <= '0;
                        r_err   <= w_illegal;
                        r_cnt   <= '0;
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        r_rdata <= r_we ? '0 : w_ldata;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_mode  (r_mode),
        .i_off   (r_addr[OFF_W-1:0]),
        .i_wdata (r_wdata),
        .i_rdata (bus_rdata),
        .o_be    (w_be),
        .o_wdata (w_bus_wdata),
        .o_rdata (w_ldata)
    );

    assign bus_we     = bus_req & r_we;
    assign bus_be     = bus_req ? w_be : '0;
    assign bus_addr   = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus_wdata  = w_bus_wdata;
    assign resp_err   = resp_valid & r_err;
    assign resp_rdata = resp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: a 32-bit unit checked every cycle against a transaction-level model,
// plus a 64-bit unit checked with literal expectations.
// Latency and lane expectations come from the access rules, not from the RTL.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_mode  = 3'b000;
    logic [31:0] req_addr  = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, bus_req, bus_we;
    logic [31:0] resp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack   = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        s_req_valid = 1'b0, s_req_we = 1'b0;
    logic [2:0]  s_req_mode  = 3'b000;
    logic [31:0] s_req_addr  = '0;
    logic [63:0] s_req_wdata = '0;
    logic        s_req_ready, s_resp_valid, s_resp_err, s_bus_req, s_bus_we;
    logic [63:0] s_resp_rdata, s_bus_wdata;
    logic [31:0] s_bus_addr;
    logic [7:0]  s_bus_be;
    logic        s_bus_ack   = 1'b0;
    logic [63:0] s_bus_rdata = '0;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_mode(req_mode),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we), .req_mode(s_req_mode),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
        .bus_req(s_bus_req), .bus_we(s_bus_we), .bus_addr(s_bus_addr), .bus_be(s_bus_be),
        .bus_wdata(s_bus_wdata), .bus_ack(s_bus_ack), .bus_rdata(s_bus_rdata)
    );

    int total = 0, bad = 0, cyc = 0, nbus = 0, nresp = 0, last_resp_cyc = 0;
    bit chk_en = 1'b0;
    logic [63:0] last_be = '0, last_wd = '0, last_rd = '0;
    logic        last_we = 1'b0, last_err = 1'b0;

    // Expected behaviour of the transaction in flight (periods are values of cyc)
    int          m_lo = 1, m_bus_hi = 0, m_ready_hi = 0, m_resp = -1;
    logic        m_we = 1'b0, m_err = 1'b0;
    logic [3:0]  m_be = '0;
    logic [31:0] m_addr = '0, m_wd = '0, m_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Access rules for a 32-bit bus, in plain arithmetic
    function automatic void model(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] rdata,
                                  output bit ill, output logic [3:0] be,
                                  output logic [31:0] bwd, output logic [31:0] rd);
        int nb, off;
        logic [63:0] field, mask;
        case (mode % 4)
            0: nb = 1;
            1: nb = 2;
            2: nb = 4;
            default: nb = 8;
        endcase
        off   = int'(addr % 4);
        ill   = (mode == 3'd3) || (mode == 3'd6) || (mode == 3'd7) || ((off % nb) != 0);
        be    = 4'(((1 << nb) - 1) << off);
        bwd   = 32'({32'h0, wdata} << (8 * off));
        field = {32'h0, rdata} >> (8 * off);
        mask  = (64'h1 << (8 * nb)) - 64'h1;
        field = field & mask;
        if ((mode < 3'd4) && (nb < 8) && field[8 * nb - 1]) field = field | ~mask;
        rd    = (we || ill) ? 32'h0 : field[31:0];
    endfunction

    // Per-cycle comparison of the 32-bit unit against the model
    always @(negedge clk) begin : cmp
        bit eb, er, ey;
        if (chk_en) begin
            eb = (cyc >= m_lo) && (cyc <= m_bus_hi);
            er = (cyc == m_resp);
            ey = !((cyc >= m_lo) && (cyc <= m_ready_hi));
            chk("req_ready", req_ready, ey);
            chk("bus_req", bus_req, eb);
            chk("resp_valid", resp_valid, er);
            if (bus_req) begin
                nbus++;
                last_be = bus_be; last_we = bus_we; last_wd = bus_wdata;
                if (eb) begin
                    chk("bus_we", bus_we, m_we);
                    chk("bus_addr", bus_addr, m_addr & ~32'h3);
                    chk("bus_be", bus_be, m_be);
                    if (m_we) chk("bus_wdata", bus_wdata, m_wd);
                end
            end
            if (resp_valid) begin
                nresp++;
                last_rd = resp_rdata; last_err = resp_err; last_resp_cyc = cyc;
                if (er) begin
                    chk("resp_err", resp_err, m_err);
                    chk("resp_rdata", resp_rdata, m_rd);
                end
            end
        end
    end

    // One access on the 32-bit unit; waits < 0 means the bus never acks
    task automatic do_acc(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                          input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                          output int a);
        bit ill;
        logic [3:0] be;
        logic [31:0] bwd, rd;
        model(we, mode, addr, wdata, rdata, ill, be, bwd, rd);
        a = cyc;
        m_we = we; m_be = be; m_addr = addr; m_wd = bwd; m_lo = a + 1;
        if (ill) begin
            m_bus_hi = a; m_resp = a + 1; m_err = 1'b1; m_rd = '0;
        end else if (waits < 0) begin
            m_bus_hi = a + TO; m_resp = a + TO + 1; m_err = 1'b1; m_rd = '0;
        end else begin
            m_bus_hi = a + 1 + waits; m_resp = a + 2 + waits; m_err = 1'b0; m_rd = rd;
        end
        m_ready_hi = m_resp;
        req_valid = 1'b1; req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ill) begin
            if (waits < 0) begin
                repeat (TO) begin @(posedge clk); #1; end
            end else begin
                repeat (waits) begin @(posedge clk); #1; end
                bus_ack = 1'b1; bus_rdata = rdata;
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_rdata = 32'h5A5A5A5A;
            end
        end
        @(posedge clk); #1;
    endtask

    // One zero-wait load on the 64-bit unit with literal expectations
    task automatic acc64(input string nm, input logic [2:0] mode, input logic [31:0] addr,
                         input logic [63:0] rdata, input logic [7:0] ebe, input logic [63:0] erd);
        chk({nm, "_ready"}, s_req_ready, 1'b1);
        s_req_valid = 1'b1; s_req_mode = mode; s_req_addr = addr;
        @(posedge clk); #1;
        s_req_valid = 1'b0;
        chk({nm, "_breq"}, s_bus_req, 1'b1);
        chk({nm, "_be"}, s_bus_be, ebe);
        chk({nm, "_addr"}, s_bus_addr, addr & ~32'h7);
        s_bus_ack = 1'b1; s_bus_rdata = rdata;
        @(posedge clk); #1;
        s_bus_ack = 1'b0;
        chk({nm, "_vld"}, s_resp_valid, 1'b1);
        chk({nm, "_err"}, s_resp_err, 1'b0);
        chk({nm, "_rd"}, s_resp_rdata, erd);
        @(posedge clk); #1;
    endtask

    initial begin
        int a, r0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_bus_be", bus_be, 4'h0);
        chk("rst_bus_we", bus_we, 1'b0);
        chk("rst64_bus_req", s_bus_req, 1'b0);
        chk_en = 1'b1;

        do_acc(1'b0, MODE_W, 32'h100, 32'h0, 2, 32'hDEADBEEF, a);
        chk("lw_be", last_be, 64'hF);
        chk("lw_rdata", last_rd, 64'hDEADBEEF);
        chk("lw_latency", 64'(last_resp_cyc - a), 64'd4);

        do_acc(1'b0, MODE_B, 32'h103, 32'h0, 0, 32'h80FFFFFF, a);
        chk("lb_be", last_be, 64'h8);
        chk("lb_rdata", last_rd, 64'hFFFFFF80);
        do_acc(1'b0, MODE_BU, 32'h103, 32'h0, 1, 32'h80FFFFFF, a);
        chk("lbu_rdata", last_rd, 64'h00000080);

        do_acc(1'b1, MODE_H, 32'h102, 32'h1234ABCD, 1, 32'hFFFFFFFF, a);
        chk("sh_we", last_we, 1'b1);
        chk("sh_be", last_be, 64'hC);
        chk("sh_wdata", last_wd, 64'hABCD0000);
        chk("sh_rdata", last_rd, 64'h0);

        r0 = nbus;
        do_acc(1'b0, MODE_H, 32'h101, 32'h0, 0, 32'h0, a);
        chk("lh_mis_err", last_err, 1'b1);
        chk("lh_mis_latency", 64'(last_resp_cyc - a), 64'd1);
        chk("lh_mis_no_bus", 64'(nbus - r0), 64'd0);

        r0 = nbus;
        do_acc(1'b0, MODE_W, 32'h200, 32'h0, -1, 32'h0, a);
        chk("to_bus_cycles", 64'(nbus - r0), 64'd4);
        chk("to_err", last_err, 1'b1);
        chk("to_latency", 64'(last_resp_cyc - a), 64'd5);

        do_acc(1'b0, MODE_W, 32'h204, 32'h0, TO - 1, 32'h13579BDF, a);
        chk("ack_at_limit_err", last_err, 1'b0);
        chk("ack_at_limit_rdata", last_rd, 64'h13579BDF);

        do_acc(1'b0, MODE_D, 32'h0, 32'h0, 0, 32'h0, a);
        chk("ld32_err", last_err, 1'b1);
        do_acc(1'b0, MODE_WU, 32'h8, 32'h0, 0, 32'h0, a);
        do_acc(1'b0, MODE_RSVD, 32'h8, 32'h0, 0, 32'h0, a);
        do_acc(1'b0, MODE_HU, 32'h102, 32'h0, 0, 32'h80010000, a);
        chk("lhu_rdata", last_rd, 64'h00008001);
        do_acc(1'b0, MODE_H, 32'h102, 32'h0, 2, 32'h80010000, a);
        chk("lh_rdata", last_rd, 64'hFFFF8001);
        do_acc(1'b1, MODE_B, 32'h101, 32'h000000AA, 0, 32'h0, a);
        chk("sb_be", last_be, 64'h2);
        chk("sb_wdata", last_wd, 64'h0000AA00);
        do_acc(1'b1, MODE_W, 32'h106, 32'h0, 0, 32'h0, a);

        r0 = nresp;
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (2) begin @(posedge clk); #1; end
        bus_ack = 1'b0;
        chk("idle_ack_ignored", 64'(nresp - r0), 64'd0);

        // Reset while the bus access is outstanding
        r0 = nresp;
        a = cyc;
        m_we = 1'b0; m_be = 4'hF; m_addr = 32'h300; m_lo = a + 1;
        m_bus_hi = a + 2; m_ready_hi = a + 2; m_resp = -1;
        req_valid = 1'b1; req_we = 1'b0; req_mode = MODE_W; req_addr = 32'h300;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_bus_abandon", bus_req, 1'b0);
        chk("rst_bus_ready", req_ready, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_bus_no_resp", 64'(nresp - r0), 64'd0);

        do_acc(1'b0, MODE_BU, 32'h301, 32'h0, 0, 32'h0000C300, a);
        chk("after_rst_rdata", last_rd, 64'h000000C3);

        acc64("ld64", MODE_D, 32'h8, 64'h0123456789ABCDEF, 8'hFF, 64'h0123456789ABCDEF);
        acc64("lw64", MODE_W, 32'hC, 64'h8000000000000000, 8'hF0, 64'hFFFFFFFF80000000);
        acc64("lwu64", MODE_WU, 32'hC, 64'h8000000000000000, 8'hF0, 64'h0000000080000000);
        acc64("lh64", MODE_H, 32'hE, 64'h1234000000000000, 8'hC0, 64'h0000000000001234);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
